uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, the receive-side counterpart of the Transmitter.
- Input is an 8N1 serial line: 1 start bit (0), SIZE_DATA data bits LSB first, 1 stop bit (1); the idle line is 1.
- Timing comes from the shared baud_generator tick i_stick, which runs at OVER_SAMPLE x baud rate.
- Each received word is written into the RX FIFO; receive-side errors are reported as single-cycle flags.

Parameters:
- SIZE_DATA, 8: number of data bits per frame.
- OVER_SAMPLE, 16: i_stick ticks per bit period.
- MID_SAMPLE, 8: tick count from the start edge to the mid-start-bit check; must be OVER_SAMPLE/2.

Ports:
- i_clk  input  1  system clock (50 MHz).
- i_rst  input  1  synchronous active-high reset.
- i_stick  input  1  oversample tick, one i_clk cycle wide.
- i_rx_serial  input  1  asynchronous serial line.
- i_fifo_full  input  1  RX FIFO full.
- o_rx_data  output  SIZE_DATA  last good received word.
- o_rx_done  output  1  one-cycle pulse; acts as the FIFO write enable for o_rx_data.
- o_valid  output  1  high from the first good frame until reset.
- o_busy  output  1  high whenever state is not IDLE.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled 0.
- o_overrun  output  1  one-cycle pulse when a good frame completes while i_fifo_full=1.

Behaviour:
- Reset (i_rst=1 at a clock edge), applied at any time including mid-frame:
  - state=IDLE; tick counter, bit counter and shift register cleared.
  - o_rx_data=0; o_rx_done, o_valid, o_busy, o_frame_err, o_overrun all 0.
  - Both synchronizer flops set to 1 (idle line level).
- Synchronizer: i_rx_serial passes through a 2-flop synchronizer; rx_s denotes its output. This adds 2 cycles of latency.
- Counters: tick counter cnt is $clog2(OVER_SAMPLE) bits; bit counter bcnt is $clog2(SIZE_DATA+1) bits. Counters change only on i_stick=1, except where a transition below resets them.
- State machine, IDLE/START/DATA/STOP:
  - IDLE: when rx_s=0 (no tick needed), go to START with cnt=0.
  - START: on each tick, cnt++. On the tick where cnt==MID_SAMPLE-1:
    - rx_s=0: go to DATA, cnt=0, bcnt=0.
    - rx_s=1: glitch; return to IDLE with no output activity.
  - DATA: on each tick, cnt++. On the tick where cnt==OVER_SAMPLE-1 (mid-bit):
    - shift register <= {rx_s, shift[SIZE_DATA-1:1]}, i.e. LSB-first fill; cnt=0; bcnt++.
    - When bcnt reaches SIZE_DATA, go to STOP.
  - STOP: on the tick where cnt==OVER_SAMPLE-1, sample the stop bit and go to IDLE:
    - rx_s=1 and i_fifo_full=0: o_rx_data<=shift, o_rx_done=1, o_valid=1.
    - rx_s=1 and i_fifo_full=1: o_overrun=1; o_rx_data and o_rx_done unchanged; the word is dropped.
    - rx_s=0: o_frame_err=1; o_rx_data unchanged, no o_rx_done. Return to IDLE anyway; IDLE re-arms only when rx_s=0, so a held-low break re-enters START.
- Output timing:
  - Pulse outputs are registered and last exactly one i_clk cycle, asserted the cycle after the deciding tick.
  - At most one of o_rx_done, o_frame_err, o_overrun pulses per frame.
- Latency: o_rx_done rises about (1.5 + SIZE_DATA) bit periods plus 3 clocks after the falling start edge on i_rx_serial. Concluding at mid-stop-bit allows back-to-back frames with no idle gap.
- Simultaneous events: i_rst has priority over everything. i_fifo_full is sampled only on the stop-bit tick.
- i_stick is never required to be aligned with i_clk phase; the sampling error is ±1 tick.

Test Plan:
- Setup: baud_generator with BAUDRATE_VALUE=325 (about 9600 baud x16). The driver sends 0x55 framed 8N1 at 104.17 us per bit -> one o_rx_done pulse, o_rx_data=0x55, o_valid=1, o_frame_err=0, o_overrun=0.
- Back-to-back frames 0x00, 0xFF, 0xA3 with no idle gap -> three o_rx_done pulses, data in that order, no errors.
- Start glitch: line low for 4 ticks (about 26 us), then high -> returns to IDLE; no pulses; o_busy high only for the glitch plus the check window.
- Frame 0xA3 with stop bit driven 0 -> o_frame_err pulses once; o_rx_data keeps its previous value; no o_rx_done.
- Frame 0x3C with i_fifo_full=1 -> o_overrun pulses once, no o_rx_done. The next frame 0xC3 with i_fifo_full=0 -> o_rx_data=0xC3.
- i_rst=1 for 2 cycles mid-DATA of frame 0x5A -> all outputs 0, state IDLE. The remaining bits of the broken frame produce no valid word unless a 0 is seen as a new start and a proper frame follows. A fresh 0x81 frame -> received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start detection, mid-bit sampling of data and stop bits,
// with one-cycle done / framing-error / overrun pulses toward the RX FIFO.
module uart_receiver #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16,
    parameter int MID_SAMPLE  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stick,
    input  logic                 i_rx_serial,
    input  logic                 i_fifo_full,
    output logic [SIZE_DATA-1:0] o_rx_data,
    output logic                 o_rx_done,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int CW = $clog2(OVER_SAMPLE);
    localparam int BW = $clog2(SIZE_DATA + 1);
    localparam logic [CW-1:0] MID_LAST  = CW'(MID_SAMPLE - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVER_SAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(SIZE_DATA - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [BW-1:0] BCNT_ZERO = {BW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic                   sync1_r, sync2_r, rx_s;
    logic [CW-1:0]          cnt_r, cnt_nxt_s;
    logic [BW-1:0]          bcnt_r, bcnt_nxt_s;
    logic [SIZE_DATA-1:0]   shift_r, shift_nxt_s;
    logic [SIZE_DATA-1:0]   rx_data_r, rx_data_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   valid_r, valid_nxt_s;
    logic                   busy_r;
    logic                   ferr_r, ferr_nxt_s;
    logic                   ovr_r, ovr_nxt_s;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= i_rx_serial;
            sync2_r <= sync1_r;
        end
    end

    assign rx_s = sync2_r;

    // Next-state, counter, shift and output-pulse decode.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bcnt_nxt_s    = bcnt_r;
        shift_nxt_s   = shift_r;
        rx_data_nxt_s = rx_data_r;
        valid_nxt_s   = valid_r;
        done_nxt_s    = 1'b0;
        ferr_nxt_s    = 1'b0;
        ovr_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = START;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (i_stick) begin
                    if (cnt_r == MID_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
                        if (!rx_s) begin
                            state_nxt_s = DATA;
                            bcnt_nxt_s  = BCNT_ZERO;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            DATA: begin
                if (i_stick) begin
                    if (cnt_r == BIT_LAST) begin
                        shift_nxt_s = {rx_s, shift_r[SIZE_DATA-1:1]};
                        cnt_nxt_s   = CNT_ZERO;
                        bcnt_nxt_s  = bcnt_r + 1'b1;
                        if (bcnt_r == BITS_LAST) begin
                            state_nxt_s = STOP;
                        end else begin
                            state_nxt_s = DATA;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            STOP: begin
                if (i_stick) begin
                    if (cnt_r == BIT_LAST) begin
                        // Decide at mid-stop so a back-to-back start edge is never missed.
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                        if (rx_s) begin
                            if (!i_fifo_full) begin
                                rx_data_nxt_s = shift_r;
                                done_nxt_s    = 1'b1;
                                valid_nxt_s   = 1'b1;
                            end else begin
                                ovr_nxt_s = 1'b1;
                            end
                        end else begin
                            ferr_nxt_s = 1'b1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
                bcnt_nxt_s  = BCNT_ZERO;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bcnt_r    <= BCNT_ZERO;
            shift_r   <= {SIZE_DATA{1'b0}};
            rx_data_r <= {SIZE_DATA{1'b0}};
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            ferr_r    <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bcnt_r    <= bcnt_nxt_s;
            shift_r   <= shift_nxt_s;
            rx_data_r <= rx_data_nxt_s;
            done_r    <= done_nxt_s;
            valid_r   <= valid_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            ferr_r    <= ferr_nxt_s;
            ovr_r     <= ovr_nxt_s;
        end
    end

    assign o_rx_data   = rx_data_r;
    assign o_rx_done   = done_r;
    assign o_valid     = valid_r;
    assign o_busy      = busy_r;
    assign o_frame_err = ferr_r;
    assign o_overrun   = ovr_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a serial driver feeds 8N1 frames, a scoreboard queue
// holds the expected pulse (kind + data) for each frame and a monitor pops it on each pulse.
module tb_uart_receiver;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = TICK_DIV * 16;

    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_FERR = 2'd2;
    localparam logic [1:0] K_OVR  = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       i_clk, i_rst, i_stick, i_rx_serial, i_fifo_full;
    logic [7:0] o_rx_data;
    logic       o_rx_done, o_valid, o_busy, o_frame_err, o_overrun;

    ev_t        sb[$];
    logic [7:0] last_data;
    logic       prev_pulse;
    int         errors;
    int         checks;
    int         tick_div;

    uart_receiver #(.SIZE_DATA(8), .OVER_SAMPLE(16), .MID_SAMPLE(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_stick     (i_stick),
        .i_rx_serial (i_rx_serial),
        .i_fifo_full (i_fifo_full),
        .o_rx_data   (o_rx_data),
        .o_rx_done   (o_rx_done),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    // Oversample tick: one clock wide, every TICK_DIV clocks, phase unrelated to the frames.
    initial begin
        i_stick  = 1'b0;
        tick_div = 1;
        forever begin
            @(negedge i_clk);
            tick_div = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
            i_stick  = (tick_div == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic line_hold(input logic v, input int clks);
        i_rx_serial = v;
        repeat (clks) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_clks);
        line_hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) line_hold(d[i], BIT_CLKS);
        line_hold(stop_v, stop_clks);
        i_rx_serial = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every pulse must match the next scoreboard entry, be alone and last one cycle.
    always @(negedge i_clk) begin
        logic       pulse_now;
        logic [1:0] kind_now;
        ev_t        e;
        pulse_now = (o_rx_done === 1'b1) || (o_frame_err === 1'b1) || (o_overrun === 1'b1);
        if (i_rst === 1'b0 && pulse_now) begin
            kind_now = (o_rx_done === 1'b1) ? K_DONE : ((o_frame_err === 1'b1) ? K_FERR : K_OVR);
            chk("one_pulse", 32'(int'(o_rx_done === 1'b1) + int'(o_frame_err === 1'b1)
                                 + int'(o_overrun === 1'b1)), 32'd1);
            chk("pulse_width", 32'(prev_pulse), 32'd0);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pulse_kind", 32'(kind_now), 32'(e.kind));
                if (kind_now == K_DONE) begin
                    chk("rx_data", 32'(o_rx_data), 32'(e.data));
                    chk("valid", 32'(o_valid), 32'd1);
                    last_data = e.data;
                end else begin
                    chk("data_hold", 32'(o_rx_data), 32'(last_data));
                end
            end
        end
        prev_pulse = pulse_now;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors      = 0;
        checks      = 0;
        last_data   = 8'h00;
        prev_pulse  = 1'b0;
        i_rst       = 1'b1;
        i_rx_serial = 1'b1;
        i_fifo_full = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_data", 32'(o_rx_data), 32'd0);
        chk("rst_done", 32'(o_rx_done), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ferr", 32'(o_frame_err), 32'd0);
        chk("rst_ovr", 32'(o_overrun), 32'd0);
        i_rst = 1'b0;
        line_hold(1'b1, 200);

        // Single frame.
        push(K_DONE, 8'h55);
        send_frame(8'h55, 1'b1, BIT_CLKS);
        line_hold(1'b1, 2 * BIT_CLKS);
        drain();
        chk("valid_after_55", 32'(o_valid), 32'd1);
        chk("data_after_55", 32'(o_rx_data), 32'h55);

        // Back-to-back frames, no idle gap.
        push(K_DONE, 8'h00);
        push(K_DONE, 8'hFF);
        push(K_DONE, 8'hA3);
        send_frame(8'h00, 1'b1, BIT_CLKS);
        send_frame(8'hFF, 1'b1, BIT_CLKS);
        send_frame(8'hA3, 1'b1, BIT_CLKS);
        line_hold(1'b1, 2 * BIT_CLKS);
        drain();

        // Start glitch of 4 ticks: busy only through the mid-start check, no pulses.
        line_hold(1'b0, 4 * TICK_DIV);
        line_hold(1'b1, 8);
        chk("glitch_busy_hi", 32'(o_busy), 32'd1);
        line_hold(1'b1, 32);
        chk("glitch_busy_lo", 32'(o_busy), 32'd0);
        line_hold(1'b1, 2 * BIT_CLKS);
        chk("glitch_no_event", 32'(sb.size()), 32'd0);

        // Stop bit low for 3/4 bit: error decided mid-stop; the re-armed start check sees high.
        push(K_FERR, 8'h00);
        send_frame(8'hA3, 1'b0, (BIT_CLKS * 3) / 4);
        line_hold(1'b1, 2 * BIT_CLKS);
        drain();
        chk("ferr_busy_lo", 32'(o_busy), 32'd0);

        // Overrun drops the word; next frame lands normally.
        i_fifo_full = 1'b1;
        push(K_OVR, 8'h00);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        i_fifo_full = 1'b0;
        line_hold(1'b1, 2 * BIT_CLKS);
        drain();
        chk("ovr_data_hold", 32'(o_rx_data), 32'hA3);
        push(K_DONE, 8'hC3);
        send_frame(8'hC3, 1'b1, BIT_CLKS);
        line_hold(1'b1, 2 * BIT_CLKS);
        drain();
        chk("data_after_c3", 32'(o_rx_data), 32'hC3);

        // Reset mid-bit 4 of 0x5A. The falling edge into bit 5 then acts as a new start;
        // it samples bits 6,7, the stop bit and idle 1s -> {1,1,1,1,1,1,0,1} = 0xFD.
        push(K_DONE, 8'hFD);
        fork
            send_frame(8'h5A, 1'b1, BIT_CLKS);
            begin
                repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(negedge i_clk);
                i_rst = 1'b1;
                repeat (2) @(negedge i_clk);
                i_rst = 1'b0;
                last_data = 8'h00;
                chk("mid_rst_data", 32'(o_rx_data), 32'd0);
                chk("mid_rst_valid", 32'(o_valid), 32'd0);
                chk("mid_rst_busy", 32'(o_busy), 32'd0);
                chk("mid_rst_pulses", 32'({o_rx_done, o_frame_err, o_overrun}), 32'd0);
            end
        join
        line_hold(1'b1, 12 * BIT_CLKS);
        drain();
        push(K_DONE, 8'h81);
        send_frame(8'h81, 1'b1, BIT_CLKS);
        line_hold(1'b1, 2 * BIT_CLKS);
        drain();
        chk("data_after_81", 32'(o_rx_data), 32'h81);
        chk("valid_after_81", 32'(o_valid), 32'd1);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
